// File: rtl/ts_failover_selector_if.sv
// rtl/ts_failover_selector_if.sv - single-cycle register bus between the QoS top level and the failover selector
interface ts_failover_selector_if;
  logic        mm_write_en;
  logic        mm_read_en;
  logic [7:0]  mm_addr;
  logic [31:0] mm_wdata;
  logic [31:0] mm_rdata;

  modport master (
    output mm_write_en, mm_read_en, mm_addr, mm_wdata,
    input  mm_rdata
  );

  modport slave (
    input  mm_write_en, mm_read_en, mm_addr, mm_wdata,
    output mm_rdata
  );
endinterface

// File: rtl/ts_failover_selector.sv
// rtl/ts_failover_selector.sv - N-channel TS failover: health tracking, error counters, priority selection
// Selection changes only on output packet boundaries unless the active input loses signal.
module ts_failover_selector #(
  parameter int NUM_CH    = 4,
  parameter int CH_W      = 3,
  parameter int ERR_W     = 8,
  parameter int TIMER_W   = 20,
  parameter int TIMER_RST = 2250
) (
  input  logic                 clk,
  input  logic                 rst,
  ts_failover_selector_if.slave mm,
  input  logic [NUM_CH-1:0]    pkt_ok,
  input  logic [NUM_CH-1:0]    pkt_err,
  input  logic [NUM_CH-1:0]    sig_present,
  input  logic                 sop_out,
  output logic [CH_W-1:0]      active_channel,
  output logic                 switch_pulse,
  output logic                 no_healthy
);

  localparam logic [7:0] A_CTRL   = 8'h00;
  localparam logic [7:0] A_PRIO   = 8'h01;
  localparam logic [7:0] A_TIMER  = 8'h02;
  localparam logic [7:0] A_STATUS = 8'h03;
  localparam logic [7:0] A_ERR0   = 8'h04;
  localparam logic [7:0] A_ERR1   = 8'h05;
  localparam logic [3:0] NUM_L    = 4'(NUM_CH);
  localparam int         NSEL     = 1 << CH_W;

  typedef enum logic {LOCKED, PENDING} state_t;

  logic               fallback_en, manual_en, revert_en;
  logic [2:0]         manual_ch;
  logic [2:0]         prio     [NUM_CH];
  logic [TIMER_W-1:0] holdoff;
  logic [TIMER_W-1:0] hold_cnt [NUM_CH];
  logic [ERR_W-1:0]   err_cnt  [NUM_CH];
  logic [NUM_CH-1:0]  healthy;
  logic [NUM_CH-1:0]  err_clr;
  logic [NSEL-1:0]    healthy_x, sig_x;
  logic [CH_W-1:0]    target, first_valid, first_healthy, pend_ch;
  logic [31:0]        rd_val;
  state_t             state;

  // pkt_ok is reserved for a future good-packet count
  logic unused_pkt_ok;
  assign unused_pkt_ok = ^pkt_ok;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++)
      healthy[i] = sig_present[i] & (hold_cnt[i] == '0) & ~pkt_err[i];
    healthy_x = '0;
    sig_x     = '0;
    healthy_x[NUM_CH-1:0] = healthy;
    sig_x[NUM_CH-1:0]     = sig_present;
  end

  always_comb begin
    err_clr = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (mm.mm_write_en && mm.mm_addr == (A_ERR0 + 8'(i / 4)) &&
          mm.mm_wdata[8*(i%4) +: 8] != 8'h00)
        err_clr[i] = 1'b1;
  end

  // Descending scan so the lowest-numbered valid entry wins without a break
  always_comb begin
    first_valid   = active_channel;
    first_healthy = active_channel;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if ({1'b0, prio[k]} < NUM_L) begin
        first_valid = CH_W'(prio[k]);
        if (healthy_x[CH_W'(prio[k])])
          first_healthy = CH_W'(prio[k]);
      end
    end
    if (manual_en && ({1'b0, manual_ch} < NUM_L))
      target = CH_W'(manual_ch);
    else if (!fallback_en)
      target = first_valid;
    else if (!revert_en && healthy_x[active_channel])
      target = active_channel;
    else
      target = first_healthy;
  end

  always_comb begin
    rd_val = '0;
    case (mm.mm_addr)
      A_CTRL:   rd_val[5:0] = {revert_en, manual_ch, manual_en, fallback_en};
      A_PRIO:   for (int k = 0; k < NUM_CH; k++) rd_val[3*k +: 3] = prio[k];
      A_TIMER:  rd_val[TIMER_W-1:0] = holdoff;
      A_STATUS: begin
        rd_val[2:0]         = 3'(active_channel);
        rd_val[8 +: NUM_CH] = healthy;
        rd_val[16 +: NUM_CH] = sig_present;
        rd_val[24]          = no_healthy;
      end
      A_ERR0, A_ERR1:
        for (int i = 0; i < NUM_CH; i++)
          if (mm.mm_addr[0] == 1'(i / 4))
            rd_val[8*(i%4) +: 8] = 8'(err_cnt[i]);
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fallback_en <= 1'b1;
      manual_en   <= 1'b0;
      manual_ch   <= 3'd0;
      revert_en   <= 1'b1;
      holdoff     <= TIMER_W'(TIMER_RST);
      mm.mm_rdata <= '0;
      for (int k = 0; k < NUM_CH; k++) prio[k] <= 3'(k);
    end else begin
      if (mm.mm_read_en)
        mm.mm_rdata <= rd_val;
      if (mm.mm_write_en) begin
        case (mm.mm_addr)
          A_CTRL:  {revert_en, manual_ch, manual_en, fallback_en} <= mm.mm_wdata[5:0];
          A_PRIO:  for (int k = 0; k < NUM_CH; k++) prio[k] <= mm.mm_wdata[3*k +: 3];
          A_TIMER: holdoff <= mm.mm_wdata[TIMER_W-1:0];
          default: ;
        endcase
      end
    end
  end

  // A clear landing on the same edge as an error leaves that one error counted
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (rst) begin
        hold_cnt[i] <= '0;
        err_cnt[i]  <= '0;
      end else begin
        if (pkt_err[i])
          hold_cnt[i] <= holdoff;
        else if (hold_cnt[i] != '0)
          hold_cnt[i] <= hold_cnt[i] - TIMER_W'(1);

        if (pkt_err[i]) begin
          if (err_clr[i])
            err_cnt[i] <= ERR_W'(1);
          else if (!(&err_cnt[i]))
            err_cnt[i] <= err_cnt[i] + ERR_W'(1);
        end else if (err_clr[i]) begin
          err_cnt[i] <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= LOCKED;
      active_channel <= '0;
      pend_ch        <= '0;
      switch_pulse   <= 1'b0;
      no_healthy     <= 1'b0;
    end else begin
      switch_pulse <= 1'b0;
      no_healthy   <= ~|healthy;
      if (!sig_x[active_channel] && target != active_channel) begin
        active_channel <= target;
        switch_pulse   <= 1'b1;
        state          <= LOCKED;
      end else begin
        case (state)
          LOCKED: begin
            if (target != active_channel) begin
              state   <= PENDING;
              pend_ch <= target;
            end
          end
          PENDING: begin
            if (target == active_channel) begin
              state <= LOCKED;
            end else if (sop_out) begin
              active_channel <= pend_ch;
              switch_pulse   <= 1'b1;
              state          <= LOCKED;
            end else begin
              pend_ch <= target;
            end
          end
          default: state <= LOCKED;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ts_failover_selector.sv
// tb/tb_ts_failover_selector.sv - self-checking bench for ts_failover_selector (NUM_CH=4)
module tb_ts_failover_selector;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] pkt_ok, pkt_err, sig_present;
  logic       sop_out;
  logic [2:0] active_channel;
  logic       switch_pulse, no_healthy;

  always #5 clk = ~clk;

  ts_failover_selector_if mm_bus();

  ts_failover_selector dut (
    .clk            (clk),
    .rst            (rst),
    .mm             (mm_bus),
    .pkt_ok         (pkt_ok),
    .pkt_err        (pkt_err),
    .sig_present    (sig_present),
    .sop_out        (sop_out),
    .active_channel (active_channel),
    .switch_pulse   (switch_pulse),
    .no_healthy     (no_healthy)
  );

  typedef struct {
    logic        we;
    logic        re;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } reg_vec_t;

  reg_vec_t    vecs [17];
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] rd;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic mm_rd(input logic [7:0] a, output logic [31:0] d);
    mm_bus.mm_read_en = 1'b1;
    mm_bus.mm_addr    = a;
    tick();
    mm_bus.mm_read_en = 1'b0;
    d = mm_bus.mm_rdata;
  endtask

  task automatic mm_wr(input logic [7:0] a, input logic [31:0] d);
    mm_bus.mm_write_en = 1'b1;
    mm_bus.mm_addr     = a;
    mm_bus.mm_wdata    = d;
    tick();
    mm_bus.mm_write_en = 1'b0;
  endtask

  task automatic err_pulse(input logic [3:0] m);
    pkt_err = m;
    tick();
    pkt_err = 4'h0;
  endtask

  initial begin
    vecs[0]  = '{1'b0, 1'b1, 8'h00, 32'h0,        32'h00000021};
    vecs[1]  = '{1'b0, 1'b1, 8'h01, 32'h0,        32'h00000688};
    vecs[2]  = '{1'b0, 1'b1, 8'h02, 32'h0,        32'd2250};
    vecs[3]  = '{1'b0, 1'b1, 8'h03, 32'h0,        32'h000F0F00};
    vecs[4]  = '{1'b0, 1'b1, 8'h04, 32'h0,        32'h00000000};
    vecs[5]  = '{1'b0, 1'b1, 8'h06, 32'h0,        32'h00000000};
    vecs[6]  = '{1'b1, 1'b1, 8'h02, 32'd100,      32'd2250};
    vecs[7]  = '{1'b0, 1'b1, 8'h02, 32'h0,        32'd100};
    vecs[8]  = '{1'b1, 1'b0, 8'h01, 32'hFFFFFFFF, 32'h0};
    vecs[9]  = '{1'b0, 1'b1, 8'h01, 32'h0,        32'h00000FFF};
    vecs[10] = '{1'b1, 1'b0, 8'h01, 32'h00000688, 32'h0};
    vecs[11] = '{1'b1, 1'b0, 8'h00, 32'hFFFFFFFF, 32'h0};
    vecs[12] = '{1'b0, 1'b1, 8'h00, 32'h0,        32'h0000003F};
    vecs[13] = '{1'b1, 1'b0, 8'h00, 32'h00000021, 32'h0};
    vecs[14] = '{1'b1, 1'b0, 8'h09, 32'h12345678, 32'h0};
    vecs[15] = '{1'b0, 1'b1, 8'h09, 32'h0,        32'h00000000};
    vecs[16] = '{1'b0, 1'b1, 8'h00, 32'h0,        32'h00000021};

    rst = 1'b1;
    pkt_ok = 4'h0;
    pkt_err = 4'h0;
    sig_present = 4'hF;
    sop_out = 1'b0;
    mm_bus.mm_write_en = 1'b0;
    mm_bus.mm_read_en  = 1'b0;
    mm_bus.mm_addr     = 8'h00;
    mm_bus.mm_wdata    = 32'h0;
    repeat (3) tick();
    check("reset active_channel", 32'(active_channel), 32'd0);
    check("reset switch_pulse", 32'(switch_pulse), 32'd0);
    check("reset no_healthy", 32'(no_healthy), 32'd0);
    rst = 1'b0;
    repeat (2) tick();

    for (int v = 0; v < 17; v++) begin
      mm_bus.mm_write_en = vecs[v].we;
      mm_bus.mm_read_en  = vecs[v].re;
      mm_bus.mm_addr     = vecs[v].addr;
      mm_bus.mm_wdata    = vecs[v].wdata;
      tick();
      mm_bus.mm_write_en = 1'b0;
      mm_bus.mm_read_en  = 1'b0;
      if (vecs[v].re) check($sformatf("reg vector %0d", v), mm_bus.mm_rdata, vecs[v].exp);
    end
    check("active after reg table", 32'(active_channel), 32'd0);

    // failover ch0 -> ch1 on error, commit only at sop_out; revert after holdoff
    err_pulse(4'b0001);
    check("err0 no immediate switch", 32'(active_channel), 32'd0);
    repeat (3) tick();
    check("pending waits for sop", 32'(active_channel), 32'd0);
    sop_out = 1'b1;
    tick();
    sop_out = 1'b0;
    check("failover to ch1", 32'(active_channel), 32'd1);
    check("failover pulse", 32'(switch_pulse), 32'd1);
    tick();
    check("pulse one cycle", 32'(switch_pulse), 32'd0);
    sop_out = 1'b1;
    for (int k = 6; k <= 101; k++) tick();
    check("no early revert", 32'(active_channel), 32'd1);
    tick();
    sop_out = 1'b0;
    check("revert to ch0", 32'(active_channel), 32'd0);
    check("revert pulse", 32'(switch_pulse), 32'd1);

    // loss of signal on the active channel switches without sop_out
    sig_present = 4'b1110;
    tick();
    check("immediate switch", 32'(active_channel), 32'd1);
    check("immediate pulse", 32'(switch_pulse), 32'd1);
    sig_present = 4'hF;
    tick();
    sop_out = 1'b1;
    tick();
    sop_out = 1'b0;
    check("back to ch0 after signal", 32'(active_channel), 32'd0);

    // manual override onto an erroring channel, then an out-of-range manual_ch
    err_pulse(4'b0100);
    mm_wr(8'h00, 32'h0000002B);
    tick();
    check("manual pending", 32'(active_channel), 32'd0);
    sop_out = 1'b1;
    tick();
    sop_out = 1'b0;
    check("manual to ch2", 32'(active_channel), 32'd2);
    mm_wr(8'h00, 32'h00000037);
    tick();
    sop_out = 1'b1;
    tick();
    sop_out = 1'b0;
    check("manual_ch 5 ignored", 32'(active_channel), 32'd0);
    mm_wr(8'h00, 32'h00000021);
    mm_rd(8'h04, rd);
    check("errcnt ch0 ch2", rd, 32'h00010001);

    // saturation and clear-with-error
    pkt_err = 4'b1000;
    repeat (300) tick();
    pkt_err = 4'h0;
    mm_rd(8'h04, rd);
    check("errcnt ch3 saturated", rd, 32'hFF010001);
    pkt_err = 4'b1000;
    mm_wr(8'h04, 32'hFF000000);
    pkt_err = 4'h0;
    mm_rd(8'h04, rd);
    check("clear with error gives 1", rd, 32'h01010001);
    mm_wr(8'h04, 32'h00000001);
    mm_rd(8'h04, rd);
    check("clear ch0 only", rd, 32'h01010000);
    check("active during ch3 errors", 32'(active_channel), 32'd0);

    // all channels erroring
    err_pulse(4'hF);
    check("no_healthy set", 32'(no_healthy), 32'd1);
    check("active kept, none healthy", 32'(active_channel), 32'd0);
    repeat (3) tick();
    mm_rd(8'h03, rd);
    check("status none healthy", rd, 32'h010F0000);
    repeat (110) tick();
    check("no_healthy cleared", 32'(no_healthy), 32'd0);
    check("active after recovery", 32'(active_channel), 32'd0);

    // revert disabled: stay on ch1 while it is healthy
    mm_wr(8'h00, 32'h00000001);
    err_pulse(4'b0001);
    sop_out = 1'b1;
    tick();
    check("norevert switch to ch1", 32'(active_channel), 32'd1);
    repeat (110) tick();
    check("norevert stays on ch1", 32'(active_channel), 32'd1);
    err_pulse(4'b0010);
    tick();
    sop_out = 1'b0;
    check("norevert leaves failed ch1", 32'(active_channel), 32'd0);
    check("norevert pulse", 32'(switch_pulse), 32'd1);

    // reset while a switch is pending discards it
    mm_wr(8'h00, 32'h00000021);
    err_pulse(4'b0001);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("reset mid-pending active", 32'(active_channel), 32'd0);
    sop_out = 1'b1;
    tick();
    sop_out = 1'b0;
    check("pending discarded", 32'(active_channel), 32'd0);
    check("no pulse after reset", 32'(switch_pulse), 32'd0);
    mm_rd(8'h02, rd);
    check("timer back to reset", rd, 32'd2250);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
